// File: rtl/s0_avmm_freeze_bridge_if.sv
// Avalon-MM command/response bundle for one side of the s0 freeze bridge.
// Latency: none (wires only). Backpressure: waitrequest from slave to master.
// Ports: address/writedata/write/read (master->slave), waitrequest/readdata/readdatavalid (slave->master).
interface s0_avmm_freeze_bridge_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic              write;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, writedata, write, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, write, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/s0_avmm_freeze_bridge.sv
// Freeze/isolation bridge between the s0 PR-region AVMM master and the static NoC slave.
// Latency: zero-cycle pass-through for commands and responses; freeze_ack is registered.
// Backpressure: s.waitrequest = !allow | m.waitrequest; reads also stall while MAX_PENDING are in flight.
// Ports: clk, rst (async, active-high); freeze_req/freeze_ack handshake with PR controller;
//   err_clear, drain_timeout_err, unexpected_rsp_err sticky flags; s = region-side slave port,
//   m = NoC-side master port.
module s0_avmm_freeze_bridge #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 32,
  parameter int MAX_PENDING   = 8,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze_req,
  output logic                    freeze_ack,
  input  logic                    err_clear,
  output logic                    drain_timeout_err,
  output logic                    unexpected_rsp_err,
  s0_avmm_freeze_bridge_if.slave  s,
  s0_avmm_freeze_bridge_if.master m
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = CNT_W'(MAX_PENDING);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pending, pending_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             hold, hold_nxt;
  logic             tmo_set, unexp_set;
  logic             allow, rd_acc, rsp, frozen, drained;

  // Data paths are straight wires; only the handshake is gated.
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] rsp_rdata;

  assign cmd_addr    = s.address;
  assign cmd_wdata   = s.writedata;
  assign rsp_rdata   = m.readdata;
  assign m.address   = cmd_addr;
  assign m.writedata = cmd_wdata;
  assign s.readdata  = rsp_rdata;

  assign frozen = (state == FROZEN);
  assign rsp    = m.readdatavalid;

  // A command already on the bus when DRAIN starts (hold) must be allowed to
  // complete; anything new is blocked outside RUN. Writes are never stalled by
  // the outstanding-read limit.
  assign allow = !frozen &&
                 (((state == RUN) && !(s.read && (pending == PEND_MAX))) || hold);

  assign m.read          = s.read  & allow;
  assign m.write         = s.write & allow;
  assign s.waitrequest   = !allow | m.waitrequest;
  assign s.readdatavalid = rsp && !frozen;

  assign rd_acc    = m.read & !m.waitrequest;
  assign drained   = (pending == '0) && !hold;
  assign unexp_set = rsp && (pending == '0) && !frozen;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    hold_nxt    = (m.read | m.write) & m.waitrequest;
    timer_nxt   = '0;
    tmo_set     = 1'b0;

    unique case ({rd_acc, rsp})
      2'b10:   pending_nxt = pending + CNT_W'(1);
      2'b01:   pending_nxt = (pending == '0) ? '0 : pending - CNT_W'(1);
      default: pending_nxt = pending;
    endcase

    unique case (state)
      RUN: begin
        if (freeze_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!freeze_req) begin
          state_nxt = RUN;
        end else if (drained) begin
          state_nxt = FROZEN;
        end else if (timer == TMR_LAST) begin
          // Give up on the stragglers: isolate anyway and forget them so a
          // later late response is dropped rather than counted.
          state_nxt   = FROZEN;
          tmo_set     = 1'b1;
          pending_nxt = '0;
          hold_nxt    = 1'b0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      FROZEN: begin
        if (!freeze_req) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= RUN;
      pending            <= '0;
      hold               <= 1'b0;
      timer              <= '0;
      freeze_ack         <= 1'b0;
      drain_timeout_err  <= 1'b0;
      unexpected_rsp_err <= 1'b0;
    end else begin
      state              <= state_nxt;
      pending            <= pending_nxt;
      hold               <= hold_nxt;
      timer              <= timer_nxt;
      freeze_ack         <= (state_nxt == FROZEN);
      // Set beats clear when both happen in the same cycle.
      drain_timeout_err  <= tmo_set   | (drain_timeout_err  & !err_clear);
      unexpected_rsp_err <= unexp_set | (unexpected_rsp_err & !err_clear);
    end
  end

endmodule

// File: tb/tb_s0_avmm_freeze_bridge.sv
module tb_s0_avmm_freeze_bridge;

  logic clk = 1'b0;
  logic rst;
  logic freeze_req, freeze_ack, err_clear;
  logic drain_timeout_err, unexpected_rsp_err;

  int total  = 0;
  int passed = 0;

  s0_avmm_freeze_bridge_if #(.ADDR_W(20), .DATA_W(32)) s_bus ();
  s0_avmm_freeze_bridge_if #(.ADDR_W(20), .DATA_W(32)) m_bus ();

  s0_avmm_freeze_bridge #(
    .ADDR_W(20), .DATA_W(32), .MAX_PENDING(8), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .freeze_req         (freeze_req),
    .freeze_ack         (freeze_ack),
    .err_clear          (err_clear),
    .drain_timeout_err  (drain_timeout_err),
    .unexpected_rsp_err (unexpected_rsp_err),
    .s                  (s_bus),
    .m                  (m_bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    freeze_req = 1'b0;
    err_clear  = 1'b0;
    s_bus.address = '0; s_bus.writedata = '0; s_bus.read = 1'b0; s_bus.write = 1'b0;
    m_bus.waitrequest = 1'b0; m_bus.readdata = '0; m_bus.readdatavalid = 1'b0;

    // Reset state
    #2;
    chk("rst_ack",   freeze_ack, 0);
    chk("rst_tmo",   drain_timeout_err, 0);
    chk("rst_unexp", unexpected_rsp_err, 0);
    chk("rst_wait",  s_bus.waitrequest, 0);
    chk("rst_mread", m_bus.read, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Pass-through read, response 3 cycles after acceptance
    s_bus.address = 20'h00010; s_bus.read = 1'b1; #1;
    chk("pt_mread", m_bus.read, 1);
    chk("pt_maddr", m_bus.address, 32'h00010);
    chk("pt_wait",  s_bus.waitrequest, 0);
    tick();
    s_bus.read = 1'b0;
    tick(); tick();
    m_bus.readdatavalid = 1'b1; m_bus.readdata = 32'hDEADBEEF; #1;
    chk("pt_rdv",   s_bus.readdatavalid, 1);
    chk("pt_rdata", s_bus.readdata, 32'hDEADBEEF);
    tick();
    m_bus.readdatavalid = 1'b0;
    chk("pt_no_unexp", unexpected_rsp_err, 0);

    // Write pass-through
    s_bus.write = 1'b1; s_bus.writedata = 32'hCAFEF00D; s_bus.address = 20'hABCDE; #1;
    chk("wr_mwrite", m_bus.write, 1);
    chk("wr_mdata",  m_bus.writedata, 32'hCAFEF00D);
    chk("wr_maddr",  m_bus.address, 32'hABCDE);
    tick();
    s_bus.write = 1'b0;

    // Stray response with pending==0 (also proves pending returned to 0)
    m_bus.readdatavalid = 1'b1; #1;
    chk("stray_rdv", s_bus.readdatavalid, 1);
    tick();
    m_bus.readdatavalid = 1'b0;
    chk("stray_unexp", unexpected_rsp_err, 1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("stray_clear", unexpected_rsp_err, 0);

    // Backpressure at MAX_PENDING=8
    s_bus.read = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("bp_mread_blk", m_bus.read, 0);
    chk("bp_wait_blk",  s_bus.waitrequest, 1);
    tick();
    chk("bp_still_blk", m_bus.read, 0);
    m_bus.readdatavalid = 1'b1; #1;
    chk("bp_rsp_rdv",  s_bus.readdatavalid, 1);
    chk("bp_rsp_mrd",  m_bus.read, 0);
    tick();
    m_bus.readdatavalid = 1'b0; #1;
    chk("bp_free_mrd",  m_bus.read, 1);
    chk("bp_free_wait", s_bus.waitrequest, 0);
    tick();
    s_bus.read = 1'b0; s_bus.write = 1'b1; #1;
    chk("bp_wr_ok", m_bus.write, 1);
    tick();
    s_bus.write = 1'b0;
    m_bus.readdatavalid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    m_bus.readdatavalid = 1'b0;
    chk("bp_drain_unexp", unexpected_rsp_err, 0);

    // Drain: 3 reads outstanding then freeze
    s_bus.read = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    s_bus.read = 1'b0; freeze_req = 1'b1;
    tick();
    s_bus.read = 1'b1; #1;
    chk("dr_mread_blk", m_bus.read, 0);
    chk("dr_wait",      s_bus.waitrequest, 1);
    chk("dr_ack0",      freeze_ack, 0);
    m_bus.readdatavalid = 1'b1; #1;
    chk("dr_rdv", s_bus.readdatavalid, 1);
    for (int i = 0; i < 3; i++) tick();
    m_bus.readdatavalid = 1'b0;
    chk("dr_ack_pre", freeze_ack, 0);
    tick();
    chk("dr_ack1",     freeze_ack, 1);
    chk("fz_wait",     s_bus.waitrequest, 1);
    chk("fz_mread",    m_bus.read, 0);
    m_bus.readdatavalid = 1'b1; #1;
    chk("fz_rdv_drop", s_bus.readdatavalid, 0);
    tick();
    m_bus.readdatavalid = 1'b0;
    chk("fz_no_unexp", unexpected_rsp_err, 0);
    s_bus.read = 1'b0; freeze_req = 1'b0;
    tick();
    chk("unfz_ack",  freeze_ack, 0);
    chk("unfz_wait", s_bus.waitrequest, 0);

    // Hold rule: write stuck in waitrequest when freeze_req rises
    s_bus.write = 1'b1; m_bus.waitrequest = 1'b1; #1;
    chk("hd_mwrite0", m_bus.write, 1);
    chk("hd_wait0",   s_bus.waitrequest, 1);
    tick();
    freeze_req = 1'b1;
    tick();
    chk("hd_mwrite_dr", m_bus.write, 1);
    tick(); tick();
    chk("hd_mwrite_4", m_bus.write, 1);
    chk("hd_ack0",     freeze_ack, 0);
    m_bus.waitrequest = 1'b0; #1;
    chk("hd_accept_wait", s_bus.waitrequest, 0);
    tick();
    chk("hd_new_blk", m_bus.write, 0);
    chk("hd_ack_pre", freeze_ack, 0);
    tick();
    chk("hd_ack1", freeze_ack, 1);
    s_bus.write = 1'b0; freeze_req = 1'b0;
    tick();

    // Drain timeout with one unanswered read
    s_bus.read = 1'b1;
    tick();
    s_bus.read = 1'b0; freeze_req = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("to_ack_pre", freeze_ack, 0);
    chk("to_err_pre", drain_timeout_err, 0);
    tick();
    chk("to_ack1", freeze_ack, 1);
    chk("to_err1", drain_timeout_err, 1);
    m_bus.readdatavalid = 1'b1; #1;
    chk("to_late_drop", s_bus.readdatavalid, 0);
    tick();
    m_bus.readdatavalid = 1'b0;
    chk("to_late_unexp", unexpected_rsp_err, 0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("to_err_clr", drain_timeout_err, 0);

    // Async reset in DRAIN with a read outstanding
    freeze_req = 1'b0;
    tick();
    s_bus.read = 1'b1;
    tick();
    s_bus.read = 1'b0; freeze_req = 1'b1;
    tick();
    s_bus.read = 1'b1; #1;
    chk("ar_pre_mread", m_bus.read, 0);
    #1 rst = 1'b1;
    #1;
    chk("ar_mread", m_bus.read, 1);
    chk("ar_wait",  s_bus.waitrequest, 0);
    chk("ar_ack",   freeze_ack, 0);
    s_bus.read = 1'b0; freeze_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    m_bus.readdatavalid = 1'b1;
    tick();
    m_bus.readdatavalid = 1'b0;
    chk("ar_pend_zero", unexpected_rsp_err, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
